// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants and types for the instruction-fetch stage.
// Holds the IF->ID bus width, reset PC default, NOP encoding, reset polarity
// and the inst-SRAM field widths, plus the buffer entry record.
package if_stage_pkg;

    // IF->ID bus carries {pc, inst}
    localparam int PcInstBusWidth = 64;

    // Instruction SRAM bus field widths
    localparam int InstAddrWidth  = 32;
    localparam int InstDataWidth  = 32;

    // First fetch address after reset
    localparam logic [InstAddrWidth-1:0] ResetPcDefault = 32'h1c00_0000;

    // andi r0,r0,0 -- delivered alongside a faulting fetch PC
    localparam logic [InstDataWidth-1:0] NopInst = 32'h0340_0000;

    // rst_n is active-low: reset is applied when rst_n equals this value
    localparam logic RstEnable = 1'b0;

    // One fetched instruction as held in the IF output buffer
    typedef struct packed {
        logic [InstAddrWidth-1:0] pc;
        logic [InstDataWidth-1:0] inst;
        logic                     adef;
    } if_buf_entry_t;

    // Build the IF->ID bus from a buffer entry
    function automatic logic [PcInstBusWidth-1:0] pack_pc_inst(input if_buf_entry_t entry);
        return {entry.pc, entry.inst};
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// if_inst_buf: single-entry {pc, inst, adef} holding register between the
// instruction SRAM response and the decode stage.
// flush empties the entry, load fills it (and wins over a same-cycle leave),
// leave empties it when decode takes the instruction.
module if_inst_buf
    import if_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  if_buf_entry_t load_entry_i,
    input  logic          leave_i,
    input  logic          flush_i,
    output logic          valid_o,
    output if_buf_entry_t entry_o
);

    logic          valid_q;
    logic          valid_d;
    if_buf_entry_t entry_q;
    if_buf_entry_t entry_d;

    // Next-state: flush beats load, load beats leave
    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            entry_d = load_entry_i;
        end else if (leave_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry register; contents cleared on reset so the bus reads zero
    always_ff @(posedge clk) begin
        if (rst_n == RstEnable) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the five-stage LoongArch pipeline.
// Owns the fetch PC, keeps at most one inst-SRAM request in flight, buffers
// one returned instruction for decode, redirects on branch or exception
// flush and drops responses that belong to the abandoned path.
// Optional build macro IF_ADEF_EN: a misaligned fetch PC issues no SRAM
// request; a NOP tagged with the faulting PC and adef=1 is handed to decode
// once, and fetch then stalls until the next redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPcDefault,
    parameter logic [31:0] NOP_INST = NopInst
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      inst_sram_req_o,
    output logic [InstAddrWidth-1:0]  inst_sram_addr_o,
    input  logic                      inst_sram_addr_ok_i,
    input  logic                      inst_sram_data_ok_i,
    input  logic [InstDataWidth-1:0]  inst_sram_rdata_i,
    input  logic                      id_allowin_i,
    input  logic                      jmp_flag_i,
    input  logic [31:0]               jmp_addr_i,
    input  logic                      excep_flush_i,
    input  logic [31:0]               excep_pc_i,
    output logic                      if_to_id_valid_o,
    output logic [PcInstBusWidth-1:0] pc_inst_o,
    output logic                      excep_adef_o
);

    // Fetch-side state
    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic [31:0] tag_q;
    logic [31:0] tag_d;
    logic        outstanding_q;
    logic        outstanding_d;
    logic        discard_q;
    logic        discard_d;

    // Buffer interface
    logic          buf_valid;
    if_buf_entry_t buf_entry;
    if_buf_entry_t load_entry;
    logic          buf_load;
    logic          buf_leave;

    // Control
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_slot;
    logic        req_fire;
    logic        resp_fire;
    logic        resp_load;
    logic        adef_block;
    logic        adef_load;

    // A flush always redirects; a branch only once decode actually moves on
    assign redirect    = excep_flush_i | (jmp_flag_i & id_allowin_i);
    assign redirect_pc = excep_flush_i ? excep_pc_i : jmp_addr_i;

    // The buffered instruction is never handed over in a redirect cycle
    assign if_to_id_valid_o = buf_valid & ~jmp_flag_i & ~excep_flush_i;
    assign buf_leave        = if_to_id_valid_o & id_allowin_i;

    // A new fetch may start only when nothing is in flight and the buffer
    // will have room by the time the response comes back. Held low while
    // reset is asserted so the request line reads zero in reset.
    assign fetch_slot = (rst_n != RstEnable) & ~outstanding_q
                      & (~buf_valid | buf_leave) & ~redirect;

    assign inst_sram_req_o  = fetch_slot & ~adef_block;
    assign inst_sram_addr_o = fetch_pc_q;

    assign req_fire  = inst_sram_req_o & inst_sram_addr_ok_i;
    assign resp_fire = inst_sram_data_ok_i & outstanding_q;
    // Wrong-path responses and responses landing in a redirect cycle are dropped
    assign resp_load = resp_fire & ~discard_q & ~redirect;

`ifdef IF_ADEF_EN
    logic adef_done_q;
    logic adef_done_d;

    assign adef_block   = (fetch_pc_q[1:0] != 2'b00);
    // Hand the faulting PC to decode exactly once per misaligned target
    assign adef_load    = fetch_slot & adef_block & ~adef_done_q;
    assign excep_adef_o = buf_entry.adef;

    // Remember that the fault entry has been produced; a redirect re-arms it
    always_comb begin
        adef_done_d = adef_done_q;
        if (redirect) begin
            adef_done_d = 1'b0;
        end else if (adef_load) begin
            adef_done_d = 1'b1;
        end
    end

    // Fault-delivered flag register
    always_ff @(posedge clk) begin
        if (rst_n == RstEnable) begin
            adef_done_q <= 1'b0;
        end else begin
            adef_done_q <= adef_done_d;
        end
    end
`else
    logic unused_adef;

    // Misaligned PCs are fetched as-is; no address fault is ever raised
    assign adef_block   = 1'b0;
    assign adef_load    = 1'b0;
    assign excep_adef_o = 1'b0;
    assign unused_adef  = buf_entry.adef;
`endif

    // Response load and fault load never coincide: one needs a request in
    // flight, the other needs none.
    assign buf_load = resp_load | adef_load;

    // Select what goes into the buffer: the fault NOP or the SRAM response
    always_comb begin
        load_entry.pc   = tag_q;
        load_entry.inst = inst_sram_rdata_i;
        load_entry.adef = 1'b0;
        if (adef_load) begin
            load_entry.pc   = fetch_pc_q;
            load_entry.inst = NOP_INST;
            load_entry.adef = 1'b1;
        end
    end

    // Fetch PC / in-flight bookkeeping; a redirect overrides the PC and
    // marks any still-pending response as wrong-path
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        tag_d         = tag_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (req_fire) begin
            outstanding_d = 1'b1;
            tag_d         = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
        end else if (resp_fire) begin
            outstanding_d = 1'b0;
            if (discard_q) begin
                discard_d = 1'b0;
            end
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            // A response arriving in this very cycle is already being dropped
            discard_d  = outstanding_q & ~inst_sram_data_ok_i;
        end
    end

    // Fetch state registers
    always_ff @(posedge clk) begin
        if (rst_n == RstEnable) begin
            fetch_pc_q    <= RESET_PC;
            tag_q         <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    if_inst_buf u_inst_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (buf_load),
        .load_entry_i (load_entry),
        .leave_i      (buf_leave),
        .flush_i      (redirect),
        .valid_o      (buf_valid),
        .entry_o      (buf_entry)
    );

    assign pc_inst_o = pack_pc_inst(buf_entry);

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage with a small
// inst-SRAM model (configurable response delay).
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        allowin;
    logic        jmp;
    logic [31:0] jmp_addr;
    logic        flush;
    logic [31:0] excep_pc;
    logic        valid;
    logic [63:0] pc_inst;
    logic        adef;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .inst_sram_req_o     (req),
        .inst_sram_addr_o    (addr),
        .inst_sram_addr_ok_i (addr_ok),
        .inst_sram_data_ok_i (data_ok),
        .inst_sram_rdata_i   (rdata),
        .id_allowin_i        (allowin),
        .jmp_flag_i          (jmp),
        .jmp_addr_i          (jmp_addr),
        .excep_flush_i       (flush),
        .excep_pc_i          (excep_pc),
        .if_to_id_valid_o    (valid),
        .pc_inst_o           (pc_inst),
        .excep_adef_o        (adef)
    );

    // ---------------- inst-SRAM model ----------------
    int          resp_delay = 0;
    logic        pend_q;
    logic [31:0] pend_addr_q;
    int          wait_q;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5a5a_0000;
    endfunction

    assign addr_ok = req;
    assign data_ok = pend_q && (wait_q == 0);
    assign rdata   = data_ok ? mem_word(pend_addr_q) : 32'h0;

    always @(posedge clk) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            wait_q      <= 0;
            pend_addr_q <= '0;
        end else if (req && addr_ok) begin
            pend_q      <= 1'b1;
            pend_addr_q <= addr;
            wait_q      <= resp_delay;
        end else if (pend_q) begin
            if (wait_q == 0) pend_q <= 1'b0;
            else             wait_q <= wait_q - 1;
        end
    end

    // Response must never hit a full buffer that is not draining
    logic proto_err = 1'b0;
    always @(negedge clk) begin
        if (rst_n && data_ok && valid && !allowin) proto_err <= 1'b1;
    end

    // ---------------- helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 2 time units into the first cycle after reset release
    task automatic apply_reset(input int delay);
        rst_n = 1'b0; jmp = 1'b0; flush = 1'b0; allowin = 1'b1;
        jmp_addr = '0; excep_pc = '0; resp_delay = delay;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; jmp = 1'b0; flush = 1'b0; allowin = 1'b1;
        jmp_addr = '0; excep_pc = '0; resp_delay = 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", req); end
            total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
            total++; if (pc_inst !== 64'h0) begin bad++; $display("FAIL reset_pc_inst got=%h want=0", pc_inst); end
            total++; if (adef !== 1'b0) begin bad++; $display("FAIL reset_adef got=%b want=0", adef); end
        end
        rst_n = 1'b1; #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL reset_first_req got=%b want=1", req); end
        total++; if (addr !== 32'h1c00_0000) begin bad++; $display("FAIL reset_first_addr got=%h want=1c000000", addr); end
        $display("test_reset: first request after release checked");
    endtask

    task automatic test_fetch_sequence();
        logic        exp_req, exp_valid;
        logic [31:0] exp_addr, exp_pc;
        apply_reset(0);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next_cycle();
            exp_req   = (c % 2 == 0);
            exp_valid = (c >= 2) && (c % 2 == 0);
            exp_addr  = 32'h1c00_0000 + 32'(2 * c);
            exp_pc    = 32'h1c00_0000 + 32'(2 * (c - 2));
            total++; if (req !== exp_req) begin bad++; $display("FAIL seq_req c=%0d got=%b want=%b", c, req, exp_req); end
            if (exp_req) begin
                total++; if (addr !== exp_addr) begin bad++; $display("FAIL seq_addr c=%0d got=%h want=%h", c, addr, exp_addr); end
            end
            total++; if (valid !== exp_valid) begin bad++; $display("FAIL seq_valid c=%0d got=%b want=%b", c, valid, exp_valid); end
            if (exp_valid) begin
                total++; if (pc_inst !== {exp_pc, mem_word(exp_pc)}) begin bad++; $display("FAIL seq_pc_inst c=%0d got=%h want=%h", c, pc_inst, {exp_pc, mem_word(exp_pc)}); end
            end
        end
        $display("test_fetch_sequence: 3 fetches at one per 2 cycles checked");
    endtask

    task automatic test_stall();
        apply_reset(0);
        next_cycle();                       // C1: response
        next_cycle(); allowin = 1'b0; #1;   // C2: first inst buffered, decode stalls
        for (int s = 0; s < 5; s++) begin
            if (s > 0) begin next_cycle(); #1; end
            total++; if (valid !== 1'b1) begin bad++; $display("FAIL stall_valid s=%0d got=%b want=1", s, valid); end
            total++; if (pc_inst !== {32'h1c00_0000, mem_word(32'h1c00_0000)}) begin bad++; $display("FAIL stall_hold s=%0d got=%h", s, pc_inst); end
            total++; if (req !== 1'b0) begin bad++; $display("FAIL stall_req s=%0d got=%b want=0", s, req); end
        end
        next_cycle(); allowin = 1'b1; #1;   // C7: handed over, next request
        total++; if (pc_inst !== {32'h1c00_0000, mem_word(32'h1c00_0000)} || valid !== 1'b1) begin bad++; $display("FAIL stall_release got=%h/%b", pc_inst, valid); end
        total++; if (req !== 1'b1 || addr !== 32'h1c00_0004) begin bad++; $display("FAIL stall_next_req got=%b/%h want=1/1c000004", req, addr); end
        next_cycle();                       // C8
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup got=%b want=0", valid); end
        next_cycle();                       // C9
        total++; if (valid !== 1'b1 || pc_inst !== {32'h1c00_0004, mem_word(32'h1c00_0004)}) begin bad++; $display("FAIL stall_second got=%b/%h", valid, pc_inst); end
        $display("test_stall: 5-cycle decode stall checked");
    endtask

    task automatic test_jump_discard();
        apply_reset(1);
        repeat (6) next_cycle();            // C6
        total++; if (valid !== 1'b1 || pc_inst !== {32'h1c00_0004, mem_word(32'h1c00_0004)}) begin bad++; $display("FAIL jd_setup got=%b/%h", valid, pc_inst); end
        total++; if (req !== 1'b1 || addr !== 32'h1c00_0008) begin bad++; $display("FAIL jd_req008 got=%b/%h", req, addr); end
        next_cycle(); jmp = 1'b1; jmp_addr = 32'h1c00_0100; #1;   // C7: 008 in flight
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL jd_valid_redirect got=%b want=0", valid); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL jd_req_redirect got=%b want=0", req); end
        next_cycle(); jmp = 1'b0; #1;       // C8: wrong-path data_ok
        total++; if (req !== 1'b0) begin bad++; $display("FAIL jd_req_discard got=%b want=0", req); end
        next_cycle();                       // C9
        total++; if (req !== 1'b1 || addr !== 32'h1c00_0100) begin bad++; $display("FAIL jd_target_req got=%b/%h want=1/1c000100", req, addr); end
        for (int i = 0; i < 2; i++) begin   // C10, C11: 008 never shows
            next_cycle();
            total++; if (valid !== 1'b0) begin bad++; $display("FAIL jd_dropped i=%0d got=%b want=0", i, valid); end
        end
        next_cycle();                       // C12
        total++; if (valid !== 1'b1 || pc_inst !== {32'h1c00_0100, mem_word(32'h1c00_0100)}) begin bad++; $display("FAIL jd_target_inst got=%b/%h", valid, pc_inst); end
        $display("test_jump_discard: wrong-path response dropped");
    endtask

    task automatic test_jump_stall();
        apply_reset(0);
        next_cycle();
        next_cycle(); jmp = 1'b1; jmp_addr = 32'h1c00_0200; allowin = 1'b0; #1;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) begin next_cycle(); #1; end
            total++; if (valid !== 1'b0 || req !== 1'b0) begin bad++; $display("FAIL js_hold s=%0d got=%b/%b want=0/0", s, valid, req); end
        end
        next_cycle(); allowin = 1'b1; #1;   // redirect cycle
        total++; if (req !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL js_redirect got=%b/%b want=0/0", req, valid); end
        next_cycle(); jmp = 1'b0; #1;
        total++; if (req !== 1'b1 || addr !== 32'h1c00_0200) begin bad++; $display("FAIL js_target_req got=%b/%h want=1/1c000200", req, addr); end
        next_cycle();
        next_cycle();
        total++; if (valid !== 1'b1 || pc_inst !== {32'h1c00_0200, mem_word(32'h1c00_0200)}) begin bad++; $display("FAIL js_target_inst got=%b/%h", valid, pc_inst); end
        $display("test_jump_stall: branch held until decode allowin");
    endtask

    task automatic test_flush_priority();
        apply_reset(0);
        next_cycle(); flush = 1'b1; excep_pc = 32'h1c00_8000; jmp = 1'b1; jmp_addr = 32'h1c00_0300; #1;
        total++; if (req !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL fp_redirect got=%b/%b want=0/0", req, valid); end
        next_cycle(); flush = 1'b0; jmp = 1'b0; #1;
        total++; if (req !== 1'b1 || addr !== 32'h1c00_8000) begin bad++; $display("FAIL fp_target_req got=%b/%h want=1/1c008000", req, addr); end
        next_cycle();
        next_cycle();
        total++; if (valid !== 1'b1 || pc_inst !== {32'h1c00_8000, mem_word(32'h1c00_8000)}) begin bad++; $display("FAIL fp_target_inst got=%b/%h", valid, pc_inst); end
        $display("test_flush_priority: flush beat branch");
    endtask

    task automatic test_wrap();
        apply_reset(0);
        jmp = 1'b1; jmp_addr = 32'hffff_fffc; #1;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL wrap_redirect_req got=%b want=0", req); end
        next_cycle(); jmp = 1'b0; #1;
        total++; if (req !== 1'b1 || addr !== 32'hffff_fffc) begin bad++; $display("FAIL wrap_req got=%b/%h want=1/fffffffc", req, addr); end
        next_cycle();
        next_cycle();
        total++; if (valid !== 1'b1 || pc_inst !== {32'hffff_fffc, mem_word(32'hffff_fffc)}) begin bad++; $display("FAIL wrap_inst got=%b/%h", valid, pc_inst); end
        total++; if (req !== 1'b1 || addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_next got=%b/%h want=1/00000000", req, addr); end
        $display("test_wrap: PC wrapped to 0");
    endtask

    task automatic test_reset_mid();
        apply_reset(0);
        next_cycle(); rst_n = 1'b0; #1;     // response in flight
        total++; if (req !== 1'b0) begin bad++; $display("FAIL mid_req got=%b want=0", req); end
        next_cycle();
        total++; if (valid !== 1'b0 || pc_inst !== 64'h0) begin bad++; $display("FAIL mid_cleared got=%b/%h want=0/0", valid, pc_inst); end
        rst_n = 1'b1; #1;
        total++; if (req !== 1'b1 || addr !== 32'h1c00_0000) begin bad++; $display("FAIL mid_restart got=%b/%h want=1/1c000000", req, addr); end
        next_cycle();
        next_cycle();
        total++; if (valid !== 1'b1 || pc_inst !== {32'h1c00_0000, mem_word(32'h1c00_0000)}) begin bad++; $display("FAIL mid_first_inst got=%b/%h", valid, pc_inst); end
        $display("test_reset_mid: mid-transaction reset cleared state");
    endtask

    task automatic test_misaligned();
        apply_reset(0);
        jmp = 1'b1; jmp_addr = 32'h1c00_0102; #1;
        next_cycle(); jmp = 1'b0; #1;
`ifdef IF_ADEF_EN
        total++; if (req !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL adef_noreq got=%b/%b want=0/0", req, valid); end
        next_cycle();
        total++; if (valid !== 1'b1 || pc_inst !== 64'h1c00_0102_0340_0000) begin bad++; $display("FAIL adef_bus got=%b/%h want=1/1c00010203400000", valid, pc_inst); end
        total++; if (adef !== 1'b1) begin bad++; $display("FAIL adef_flag got=%b want=1", adef); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL adef_req got=%b want=0", req); end
        next_cycle();
        total++; if (valid !== 1'b0 || req !== 1'b0) begin bad++; $display("FAIL adef_stalled got=%b/%b want=0/0", valid, req); end
        next_cycle(); flush = 1'b1; excep_pc = 32'h1c00_0000; #1;
        next_cycle(); flush = 1'b0; #1;
        total++; if (req !== 1'b1 || addr !== 32'h1c00_0000) begin bad++; $display("FAIL adef_recover got=%b/%h want=1/1c000000", req, addr); end
        next_cycle();
        next_cycle();
        total++; if (valid !== 1'b1 || adef !== 1'b0 || pc_inst !== {32'h1c00_0000, mem_word(32'h1c00_0000)}) begin bad++; $display("FAIL adef_after got=%b/%b/%h", valid, adef, pc_inst); end
`else
        total++; if (req !== 1'b1 || addr !== 32'h1c00_0102) begin bad++; $display("FAIL misal_req got=%b/%h want=1/1c000102", req, addr); end
        next_cycle();
        next_cycle();
        total++; if (valid !== 1'b1 || pc_inst !== {32'h1c00_0102, mem_word(32'h1c00_0102)}) begin bad++; $display("FAIL misal_inst got=%b/%h", valid, pc_inst); end
        total++; if (adef !== 1'b0) begin bad++; $display("FAIL misal_adef got=%b want=0", adef); end
`endif
        $display("test_misaligned: misaligned target checked");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_sequence();
        test_stall();
        test_jump_discard();
        test_jump_stall();
        test_flush_priority();
        test_wrap();
        test_reset_mid();
        test_misaligned();
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_resp_into_full_buf got=%b want=0", proto_err); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
